// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter: state encodings,
// default bus widths and the requester-id width helper.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_RESP  = 3'b100
  } state_t;

  // Width of a requester index; never below one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest set bit of i_eff at or above
// i_ptr, wrapping, found by masking a doubled request vector.
module mem_arbiter_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_eff,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid_c,
  output logic [IDX_W-1:0] o_idx_c
);

  logic [2*N-1:0] w_dbl;

  always_comb begin
    w_dbl     = {i_eff, i_eff};
    o_valid_c = |i_eff;
    o_idx_c   = '0;
    for (int j = 0; j < int'(2 * N); j++) begin
      if (j < int'(i_ptr)) w_dbl[j] = 1'b0;
    end
    // Descending scan so the lowest surviving bit is the final assignment.
    for (int j = int'(2 * N) - 1; j >= 0; j--) begin
      if (w_dbl[j]) o_idx_c = IDX_W'(j % int'(N));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between
// N_CORES requesters; every transaction takes three cycles to its ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  localparam int unsigned ID_W   = id_w(N_CORES)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_CORES-1:0]        i_req,
  input  logic [N_CORES-1:0]        i_we,
  input  logic [N_CORES*ADDR_W-1:0] i_addr,
  input  logic [N_CORES*DATA_W-1:0] i_wdata,
  output logic [N_CORES-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic [N_CORES-1:0]  r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic [ID_W-1:0]     r_grant_id, w_grant_id_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_mem_en, w_mem_en_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_wr, w_wr_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;

  logic [N_CORES-1:0]  w_eff;
  logic                w_pick_valid;
  logic [ID_W-1:0]     w_pick_idx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // A core's request is ignored during its own ack cycle.
  assign w_eff       = i_req & ~r_ack;
  assign w_sel_addr  = i_addr[int'(w_pick_idx) * int'(ADDR_W) +: ADDR_W];
  assign w_sel_wdata = i_wdata[int'(w_pick_idx) * int'(DATA_W) +: DATA_W];

  mem_arbiter_rr_pick #(
    .N     (N_CORES),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .i_eff     (w_eff),
    .i_ptr     (r_ptr),
    .o_valid_c (w_pick_valid),
    .o_idx_c   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_ack_nxt       = r_ack;
    w_rdata_nxt     = r_rdata;
    w_grant_id_nxt  = r_grant_id;
    w_busy_nxt      = r_busy;
    w_mem_en_nxt    = r_mem_en;
    w_mem_we_nxt    = r_mem_we;
    w_wr_nxt        = r_wr;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        w_ack_nxt    = '0;
        w_mem_en_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
        if (w_pick_valid) begin
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = i_we[w_pick_idx];
          w_wr_nxt        = i_we[w_pick_idx];
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
          w_grant_id_nxt  = w_pick_idx;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_mem_en_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
        w_state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        if (!r_wr) w_rdata_nxt = i_mem_rdata;
        w_ack_nxt   = N_CORES'(1) << r_grant_id;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = (r_grant_id == ID_W'(N_CORES - 1)) ? '0 : r_grant_id + ID_W'(1);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_ptr_nxt       = '0;
        w_ack_nxt       = '0;
        w_rdata_nxt     = '0;
        w_grant_id_nxt  = '0;
        w_busy_nxt      = 1'b0;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_wr_nxt        = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_wr        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_wr        <= w_wr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_grant_id  = r_grant_id;
  assign o_busy      = r_busy;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous-read memory model.
module tb_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [1:0]      grant_id;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_grant_id  (grant_id),
    .o_busy      (busy),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // Memory does not see the arbiter reset, so an issued write always lands.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    we[k]          = w;
    addr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
    req[k]         = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) mem[8'h10 + k] = 32'hA0 + 32'(k);
    mem_rdata = '0;
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;

    // Idle bus keeps every output at its reset value
    for (int c = 0; c < 20; c++) begin
      chk("idle_strobes", {ack, mem_en, mem_we, busy}, 0);
    end
    chk("idle_regs", {rdata, grant_id, mem_addr[15:0]}, 0);
    chk("idle_wdata", mem_wdata, 0);
    for (int c = 0; c < 20; c++) tick();
    chk("idle_after20", {ack, mem_en, mem_we, busy, grant_id}, 0);

    // Single read by core1
    set_core(1, 1'b0, 32'h10, 32'h0);
    tick();
    chk("rd_issue_en", {mem_en, mem_we, busy}, 3'b101);
    chk("rd_issue_addr", mem_addr, 32'h10);
    chk("rd_issue_gid", grant_id, 1);
    chk("rd_issue_ack", ack, 0);
    tick();
    chk("rd_resp_en", {mem_en, busy, ack}, 6'b010000);
    tick();
    chk("rd_ack", ack, 4'b0010);
    chk("rd_data", rdata, 32'hDEADBEEF);
    chk("rd_busy", busy, 0);
    req = '0;
    tick();
    chk("rd_ack_pulse", ack, 0);
    chk("rd_data_hold", rdata, 32'hDEADBEEF);

    // Core2 write, then core0 reads it back
    set_core(2, 1'b1, 32'h20, 32'h12345678);
    tick();
    chk("wr_issue", {mem_en, mem_we, grant_id}, 4'b1110);
    chk("wr_addr", mem_addr, 32'h20);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    tick();
    chk("wr_we_one_cycle", {mem_en, mem_we}, 0);
    tick();
    chk("wr_ack", ack, 4'b0100);
    chk("wr_rdata_hold", rdata, 32'hDEADBEEF);
    req = '0;
    tick();
    chk("wr_committed", mem[8'h08], 32'h12345678);
    set_core(0, 1'b0, 32'h20, 32'h0);
    tick();
    chk("rb_gid", grant_id, 0);
    tick(); tick();
    chk("rb_ack", ack, 4'b0001);
    chk("rb_data", rdata, 32'h12345678);
    req = '0;
    tick();

    // All four cores contend right after reset
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) set_core(k, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_gid", grant_id, 64'(k));
      chk("cont_addr", mem_addr, 32'h40 + 32'(4 * k));
      tick(); tick();
      chk("cont_ack", ack, 64'(4'b0001 << k));
      chk("cont_data", rdata, 32'hA0 + 32'(k));
      req[k] = 1'b0;
    end
    tick();
    chk("cont_done", {ack, busy}, 0);

    // Fairness: core0 re-requests continuously, core3 arrives mid-transaction
    reset = 1'b1; tick(); reset = 1'b0;
    set_core(0, 1'b0, 32'h40, 32'h0);
    tick();
    chk("fair_g0", grant_id, 0);
    set_core(3, 1'b0, 32'h4C, 32'h0);
    tick(); tick();
    chk("fair_ack0", ack, 4'b0001);
    tick();
    chk("fair_g3", grant_id, 3);
    tick(); tick();
    chk("fair_ack3", ack, 4'b1000);
    chk("fair_data3", rdata, 32'hA3);
    req[3] = 1'b0;
    set_core(1, 1'b0, 32'h44, 32'h0);
    tick();
    chk("fair_wrap_g0", grant_id, 0);
    tick(); tick();
    chk("fair_ack0b", ack, 4'b0001);
    chk("fair_data0", rdata, 32'hA0);
    req[0] = 1'b0;
    tick();
    chk("fair_g1", grant_id, 1);
    tick(); tick();
    chk("fair_ack1", ack, 4'b0010);
    chk("fair_data1", rdata, 32'hA1);
    req = '0;
    tick();

    // Reset during a write's issue cycle
    set_core(2, 1'b1, 32'h30, 32'hCAFEF00D);
    tick();
    chk("rst_wr_issue", {mem_en, mem_we}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0; req = '0;
    chk("rst_outs", {ack, busy, mem_en, mem_we, grant_id}, 0);
    chk("rst_regs", {rdata, mem_addr}, 0);
    chk("rst_wr_committed", mem[8'h0C], 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_no_ack", {ack, busy}, 0);
    end
    set_core(1, 1'b0, 32'h44, 32'h0);
    set_core(3, 1'b0, 32'h4C, 32'h0);
    tick();
    chk("rst_ptr_zero", grant_id, 1);
    tick(); tick();
    chk("rst_next_ack", ack, 4'b0010);
    req = '0;
    tick();

    // Reset on the same edge as arbitration issues nothing
    set_core(0, 1'b1, 32'h34, 32'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0; req = '0;
    chk("rst_arb_quiet", {mem_en, mem_we, busy}, 0);
    tick(); tick();
    chk("rst_arb_nowrite", mem[8'h0D], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter sharing one single-port, synchronous-read data memory between N_CORES rv32e cores in the multiprocessor top level.
- Each core presents a request with address, write data and write enable, then waits for a one-hot ack.
- The ack is consumed by the per-core stall logic.
- All memory-side outputs and acks are registered. Every transaction, read or write, has fixed, uniform latency.

Parameters:
N_CORES, 4, number of requesters; must be ≥2
ADDR_W, 32, address width; byte address passed through unchanged
DATA_W, 32, data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  N_CORES  per-core request, held until ack
we  in  N_CORES  per-core write enable; 1=store word, 0=load word
addr  in  N_CORES*ADDR_W  packed per-core address; core i at [i*ADDR_W +: ADDR_W]
wdata  in  N_CORES*DATA_W  packed per-core store data
ack  out  N_CORES  one-hot, one-cycle pulse; transaction for that core is complete
rdata  out  DATA_W  load data broadcast to all cores; valid while ack is high
grant_id  out  $clog2(N_CORES)  index of the core currently or last served
busy  out  1  high in ST_ISSUE and ST_RESP
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid one cycle after mem_en

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: state=ST_IDLE, ptr=0, ack=0, rdata=0, grant_id=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States are one-hot: ST_IDLE=3'b001, ST_ISSUE=3'b010, ST_RESP=3'b100. Any illegal encoding takes the reset action.
- ST_IDLE:
  - Clear ack.
  - Compute eff = req & ~ack, so a core's stale request in its own ack cycle is ignored.
  - If eff≠0:
    - Winner w = first set bit of eff, scanning upward from ptr and wrapping N_CORES-1→0.
    - Register mem_en=1, mem_we=we[w], mem_addr=addr[w], mem_wdata=wdata[w], grant_id=w, busy=1.
    - Go to ST_ISSUE.
  - Otherwise stay in ST_IDLE; mem_en and mem_we stay 0.
- ST_ISSUE: memory samples the strobes at the end of this cycle. Register mem_en=0, mem_we=0. Go to ST_RESP.
- ST_RESP:
  - mem_rdata is valid.
  - Register rdata=mem_rdata for reads; for writes, rdata holds its old value.
  - Register ack[grant_id]=1, busy=0, ptr=(grant_id+1) mod N_CORES.
  - Go to ST_IDLE.
- Latency: request sampled at edge T → ack high in cycle T+3. Throughput is one transaction per 3 cycles, because the ack cycle is also the next arbitration cycle.
- Requester rules:
  - addr, we and wdata must be stable from req rise until ack.
  - req must be deasserted, or reasserted as a new request, in the cycle after ack.
  - Requests are never dropped; a request deasserted before its grant is simply not served.
- Fairness: a continuously requesting core waits at most N_CORES-1 transactions.
- mem_addr and mem_wdata hold their last values while idle. Only mem_en and mem_we qualify them.
- Reset mid-operation:
  - A write whose ST_ISSUE edge has already occurred is committed in memory, but no ack is issued.
  - A reset in the same edge as ST_IDLE→ST_ISSUE issues nothing.
  - All outputs return to their reset values.

Decomposition:
- Shared package/header mem_arb_defs.v holds:
  - ST_IDLE, ST_ISSUE and ST_RESP encodings;
  - the id width function;
  - default ADDR_W and DATA_W.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: eff[N_CORES], ptr.
  - Outputs: valid, idx.
  - Implemented as a double-width mask-and-priority-encode.
- The FSM and datapath registers stay in mem_arbiter.

Test Plan:
1. Single read: memory[0x10]=0xDEADBEEF; core1 req, we=0, addr=0x10 at edge T → mem_en high only in cycle T+1 with mem_addr=0x10 and mem_we=0; ack=4'b0010 in cycle T+3; rdata=0xDEADBEEF.
2. Write then read back: core2 writes 0x12345678 to 0x20 → mem_we high exactly one cycle with those values, ack[2] at T+3; core0 then reads 0x20 → rdata=0x12345678.
3. Contention after reset: all 4 cores request at T → service order 0,1,2,3; acks at T+3, T+6, T+9, T+12; grant_id follows 0→3.
4. Fairness: core0 re-requests immediately after every ack; core3 requests mid-transaction → core3 is acked before core0's second subsequent ack; ptr wraps 3→0.
5. Reset during a write's ST_ISSUE cycle → write committed in memory, no ack pulse; next cycle state=ST_IDLE, busy=0, mem_en=0, ptr=0.
6. Idle bus: req=0 for 20 cycles → mem_en, mem_we and ack stay 0; all outputs keep their reset values.
